// File: rtl/mdu_riscv_if.sv
// rtl/mdu_riscv_if.sv - issue/writeback bundle between control, register file and the RV32M unit
interface mdu_riscv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  // Issuing side: control pipeline plus register file read ports
  modport master (
    output start, op, a, b, rd,
    input  busy, wb_we, wb_addr, wb_data
  );

  // The multiply/divide unit itself
  modport slave (
    input  start, op, a, b, rd,
    output busy, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/mdu_riscv.sv
// rtl/mdu_riscv.sv - iterative RV32M multiply/divide unit (optional early-out: MDU_EARLY_OUT_EN)
module mdu_riscv #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  mdu_riscv_if.slave   mdu
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_IT = CW'(XLEN - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d;        // raw dividend, returned by REM/REMU on divide by zero
  logic [XLEN-1:0]   ua_q, ua_d;      // |a| under the op's signedness
  logic [XLEN-1:0]   ub_q, ub_d;      // |b| under the op's signedness
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [2*XLEN-1:0] prod_q, prod_d;  // high half accumulates, low half shifts out multiplier bits
  logic [XLEN-1:0]   rem_q, rem_d;    // partial remainder, always below the divisor
  logic [XLEN-1:0]   quo_q, quo_d;    // dividend bits shift out the top, quotient bits shift in
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
`ifdef MDU_EARLY_OUT_EN
  logic              hold_q, hold_d;  // extra FIX cycle so an early-out write lands at N+2
`endif

  // Accept-time operand decode
  logic            in_a_signed, in_b_signed;
  logic            in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_ua, in_ub;
  logic            in_div0, in_ovf;

  // Iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] rem_diff;
  logic            rem_ok;

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_sgn;
  logic [XLEN-1:0]   quo_sgn, rem_sgn;
  logic [XLEN-1:0]   mul_res, div_res, result;

  assign mdu.busy    = (state_q != S_IDLE);
  assign mdu.wb_we   = (state_q == S_DONE) && (rd_q != 5'd0);
  assign mdu.wb_addr = wb_addr_q;
  assign mdu.wb_data = wb_data_q;

  // Decode operand signedness and magnitudes from the issue bus
  always_comb begin
    in_a_signed = 1'b0;
    in_b_signed = 1'b0;
    case (mdu.op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        in_a_signed = 1'b1;
        in_b_signed = 1'b1;
      end
      OP_MULHSU: in_a_signed = 1'b1;
      default: ;
    endcase
    in_a_neg = in_a_signed & mdu.a[XLEN-1];
    in_b_neg = in_b_signed & mdu.b[XLEN-1];
    in_ua    = in_a_neg ? -mdu.a : mdu.a;
    in_ub    = in_b_neg ? -mdu.b : mdu.b;
    in_div0  = mdu.op[2] && (mdu.b == '0);
    in_ovf   = ((mdu.op == OP_DIV) || (mdu.op == OP_REM)) &&
               (mdu.a == MIN_NEG) && (mdu.b == '1);
  end

  // One shift-add step and one restoring-division step
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? ua_q : '0)};
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, ub_q};
    rem_ok    = ~rem_diff[XLEN+1];
  end

  // Sign fix-up and special-case override of the iterative result
  always_comb begin
    prod_sgn = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    quo_sgn  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    rem_sgn  = a_neg_q ? -rem_q : rem_q;
    mul_res  = (op_q == OP_MUL) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
    if (div0_q) begin
      div_res = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      div_res = op_q[1] ? '0 : MIN_NEG;
    end else begin
      div_res = op_q[1] ? rem_sgn : quo_sgn;
    end
    result = op_q[2] ? div_res : mul_res;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    ua_d      = ua_q;
    ub_d      = ub_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
`ifdef MDU_EARLY_OUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          op_d    = mdu.op;
          rd_d    = mdu.rd;
          a_d     = mdu.a;
          ua_d    = in_ua;
          ub_d    = in_ub;
          a_neg_d = in_a_neg;
          b_neg_d = in_b_neg;
          div0_d  = in_div0;
          ovf_d   = in_ovf;
          prod_d  = {{XLEN{1'b0}}, in_ub};
          rem_d   = '0;
          quo_d   = in_ua;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef MDU_EARLY_OUT_EN
          if (in_div0 || in_ovf) begin
            state_d = S_FIX;
            hold_d  = 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          rem_d = rem_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], rem_ok};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        wb_data_d = result;
        wb_addr_d = rd_q;
        state_d   = S_DONE;
`ifdef MDU_EARLY_OUT_EN
        if (hold_q) begin
          hold_d  = 1'b0;
          state_d = S_FIX;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      ua_q      <= '0;
      ub_q      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
`ifdef MDU_EARLY_OUT_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      ua_q      <= ua_d;
      ub_q      <= ub_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
`ifdef MDU_EARLY_OUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_riscv.sv
// tb/tb_mdu_riscv.sv - directed self-checking bench for mdu_riscv
module tb_mdu_riscv;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 2;
`else
  localparam int LAT_SPECIAL = 33;
`endif
  localparam int LAT = 33;

  mdu_riscv_if #(.XLEN(32)) bus ();

  mdu_riscv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one op, scramble the bus after acceptance, then track the write pulse and busy drop.
  task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] rdv, input logic [31:0] expd, input int lat,
                        input int glitch_k, input string tag);
    int          pulses;
    int          pulse_k;
    int          drop_k;
    logic [31:0] got_d;
    logic [4:0]  got_a;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = f;
    bus.a     = av;
    bus.b     = bv;
    bus.rd    = rdv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'b011;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h0000_0003;
    bus.rd    = 5'd9;
    chk({tag, " busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
    pulses  = 0;
    pulse_k = -1;
    drop_k  = -1;
    got_d   = '0;
    got_a   = '0;
    for (int k = 1; k <= 40 && drop_k < 0; k++) begin
      if (k == glitch_k) begin
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd9;
        bus.b     = 32'd4;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.wb_we) begin
        pulses++;
        got_d = bus.wb_data;
        got_a = bus.wb_addr;
        if (pulse_k < 0) pulse_k = k;
      end
      if (!bus.busy) drop_k = k;
    end
    chk({tag, " pulses"}, pulses, (rdv != 5'd0) ? 32'd1 : 32'd0);
    if (rdv != 5'd0) begin
      chk({tag, " we_cycle"}, pulse_k, lat);
      chk({tag, " wb_data"}, got_d, expd);
      chk({tag, " wb_addr"}, {27'd0, got_a}, {27'd0, rdv});
    end
    chk({tag, " busy_drop"}, drop_k, lat + 1);
  endtask

  initial begin
    int pulses;
    checks    = 0;
    failures  = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset wb_we", {31'd0, bus.wb_we}, 32'd0);
    chk("reset wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    chk("reset wb_data", bus.wb_data, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT, 0, "mul_7_neg3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, LAT, 0, "mulh_min");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, LAT, 0, "mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, LAT, 0, "mulhsu_neg1");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFD, LAT, 0, "div_neg7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFF, LAT, 0, "rem_neg7_2");
    run_op(3'b101, 32'd100,      32'd7,        5'd12, 32'd14,        LAT, 0, "divu_100_7");
    run_op(3'b111, 32'd100,      32'd7,        5'd13, 32'd2,         LAT, 0, "remu_100_7");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, LAT_SPECIAL, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,        LAT_SPECIAL, 0, "rem_ovf");
    run_op(3'b101, 32'd5,        32'd0,        5'd16, 32'hFFFF_FFFF, LAT_SPECIAL, 0, "divu_by0");
    run_op(3'b111, 32'd5,        32'd0,        5'd17, 32'd5,         LAT_SPECIAL, 0, "remu_by0");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0,        5'd18, 32'hFFFF_FFFF, LAT_SPECIAL, 0, "div_by0");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0,        5'd19, 32'hFFFF_FFF9, LAT_SPECIAL, 0, "rem_by0");
    run_op(3'b000, 32'd3,        32'd4,        5'd20, 32'd12,        LAT, 10, "mul_start_while_busy");
    run_op(3'b000, 32'd3,        32'd4,        5'd0,  32'd12,        LAT, 0, "mul_rd0");

    // Reset in the middle of a DIVU: everything clears at once and no write follows
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b101;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    bus.rd    = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midop_reset busy", {31'd0, bus.busy}, 32'd0);
    chk("midop_reset wb_we", {31'd0, bus.wb_we}, 32'd0);
    chk("midop_reset wb_data", bus.wb_data, 32'd0);
    chk("midop_reset wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.wb_we) pulses++;
    end
    chk("midop_reset no_write", pulses, 32'd0);
    run_op(3'b000, 32'd2, 32'd3, 5'd21, 32'd6, LAT, 0, "mul_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
